scancode_ascii_rom: RTL and testbench
=====================================

Name: scancode_ascii_rom

Overview:
- Synchronous lookup ROM that maps an 8-bit PS/2 Set-2 make code to three 8-bit ASCII views:
  - lowercase/unshifted
  - uppercase (Caps)
  - shifted-symbol
- Sits between the PS/2 keyboard receiver and the keyboard controller.
- The controller registers the scan code as the address. It selects `q_s` when Shift is held and `q_s` differs from both `q_h` and `q_l`; otherwise it selects `q_h` or `q_l` from its case flag.
- One block provides all three tables that would otherwise be three single-output ROMs.

Parameters:
- UNMAPPED, 8'h00, value output on all three ports for any code not in the table.

Ports:
- clock  in   1  system clock; all state updates on rising edge.
- reset  in   1  synchronous, active-high reset.
- address  in  8  PS/2 Set-2 scan code.
- q_l  out  8  lowercase/unshifted ASCII.
- q_h  out  8  uppercase ASCII.
- q_s  out  8  shifted-symbol ASCII.

Behaviour:
- Fully synchronous; one clock of latency.
  - `address` is sampled on rising edge N.
  - `q_l`/`q_h`/`q_s` show the table entry after edge N and hold it until the next edge.
- Reset:
  - When `reset`=1 at a rising edge, all three outputs become 8'h00 and `address` is ignored for that edge.
  - The first valid lookup appears one edge after `reset` falls.
- No enable and no handshake: a lookup happens every cycle.
- Table rules, code -> (q_l, q_h, q_s):
  - Letters: q_l = lowercase, q_h = uppercase, q_s = uppercase (q_s must equal q_h so the controller falls back to its case flag).
    - A 1C, B 32, C 21, D 23, E 24, F 2B, G 34, H 33, I 43, J 3B, K 42, L 4B, M 3A
    - N 31, O 44, P 4D, Q 15, R 2D, S 1B, T 2C, U 3C, V 2A, W 1D, X 22, Y 35, Z 1A
  - Digits: q_l = q_h = digit; q_s = US shifted symbol.
    - 1 16 '!', 2 1E '@', 3 26 '#', 4 25 '$', 5 2E '%'
    - 6 36 '^', 7 3D '&', 8 3E '*', 9 46 '(', 0 45 ')'
  - Punctuation: q_l = q_h = base; q_s = shifted.
    - 0E '`'/'~', 4E '-'/'_', 55 '='/'+'
    - 54 '['/'{', 5B ']'/'}', 5D '\'/'|'
    - 4C ';'/':', 52 '''/'"'
    - 41 ','/'<', 49 '.'/'>', 4A '/'/'?'
  - Control keys: all three outputs equal.
    - Space 29 -> 20
    - Enter 5A -> 0D
    - Backspace 66 -> 08
    - Tab 0D -> 09
    - Esc 76 -> 1B
  - All other codes output UNMAPPED on all three ports. This includes F0 (break prefix), E0 (extended prefix), 12/59 (Shift), 58 (Caps), 14, 11 and F-keys.
- Invariant for every address: q_s equals q_h, or differs from both q_l and q_h.
- Back-to-back address changes give back-to-back results; nothing is buffered beyond one stage.
- Reset asserted mid-stream forces 00 on the next edge, whatever the address.

Test Plan:
- Reset: hold reset=1, address=1C, one edge -> q_l=q_h=q_s=00. Release with address=1C -> after next edge q_l=61, q_h=41, q_s=41.
- Latency: change address 1C->16 between edges -> outputs stay 61/41/41 until the next edge, then q_l=31, q_h=31, q_s=21.
- Punctuation sweep: 4A -> 2F/2F/3F; 52 -> 27/27/22; 0E -> 60/60/7E; 55 -> 3D/3D/2B.
- Control keys: 29 -> 20/20/20; 5A -> 0D/0D/0D; 66 -> 08/08/08.
- Unmapped: F0, E0, 12, 58, FF, 00 -> 00/00/00 each.
- Exhaustive: sweep addresses 00..FF, one per cycle, against the golden table.
  - Check the invariant (q_s==q_h, or q_s differs from both q_l and q_h) on every code.
  - Check all 26 letters have q_h = q_l - 8'h20.

Source files
------------

// File: rtl/scancode_ascii_rom.sv
// ----------------------------------------------------------------------------
// scancode_ascii_rom
//
// Purpose:
//   Registered lookup ROM from an 8-bit PS/2 Set-2 make code to three ASCII
//   views of the key: unshifted/lowercase, uppercase (Caps) and shifted
//   symbol. One clock of latency: the address sampled on edge N is reflected
//   on all three outputs after edge N and held until the next edge.
//
//   There is no valid/ready handshake and no enable: a lookup happens on
//   every rising edge, so back-to-back addresses give back-to-back results.
//
//   Table invariant relied on by the keyboard controller: for every address
//   q_s either equals q_h (letters, control keys, unmapped codes) or differs
//   from both q_l and q_h (digits, punctuation). The controller picks q_s
//   only in the second case when Shift is held.
//
// Ports:
//   clock    in   1  system clock, rising-edge active
//   reset    in   1  synchronous active-high reset; outputs forced to 8'h00
//   address  in   8  PS/2 Set-2 scan code
//   q_l      out  8  lowercase / unshifted ASCII
//   q_h      out  8  uppercase ASCII
//   q_s      out  8  shifted-symbol ASCII
// ----------------------------------------------------------------------------
module scancode_ascii_rom #(
   parameter logic [7:0] UNMAPPED = 8'h00
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [7:0] address,
   output logic [7:0] q_l,
   output logic [7:0] q_h,
   output logic [7:0] q_s
);

   logic [7:0] l_d, h_d, s_d;
   logic [7:0] l_q, h_q, s_q;

   // Combinational table; the only storage is the output register below.
   always_comb begin
      l_d = UNMAPPED;
      h_d = UNMAPPED;
      s_d = UNMAPPED;
      unique case (address)
         // Letters: q_s mirrors q_h so the controller falls back to Caps.
         8'h1C: begin l_d = 8'h61; h_d = 8'h41; s_d = 8'h41; end // a
         8'h32: begin l_d = 8'h62; h_d = 8'h42; s_d = 8'h42; end // b
         8'h21: begin l_d = 8'h63; h_d = 8'h43; s_d = 8'h43; end // c
         8'h23: begin l_d = 8'h64; h_d = 8'h44; s_d = 8'h44; end // d
         8'h24: begin l_d = 8'h65; h_d = 8'h45; s_d = 8'h45; end // e
         8'h2B: begin l_d = 8'h66; h_d = 8'h46; s_d = 8'h46; end // f
         8'h34: begin l_d = 8'h67; h_d = 8'h47; s_d = 8'h47; end // g
         8'h33: begin l_d = 8'h68; h_d = 8'h48; s_d = 8'h48; end // h
         8'h43: begin l_d = 8'h69; h_d = 8'h49; s_d = 8'h49; end // i
         8'h3B: begin l_d = 8'h6A; h_d = 8'h4A; s_d = 8'h4A; end // j
         8'h42: begin l_d = 8'h6B; h_d = 8'h4B; s_d = 8'h4B; end // k
         8'h4B: begin l_d = 8'h6C; h_d = 8'h4C; s_d = 8'h4C; end // l
         8'h3A: begin l_d = 8'h6D; h_d = 8'h4D; s_d = 8'h4D; end // m
         8'h31: begin l_d = 8'h6E; h_d = 8'h4E; s_d = 8'h4E; end // n
         8'h44: begin l_d = 8'h6F; h_d = 8'h4F; s_d = 8'h4F; end // o
         8'h4D: begin l_d = 8'h70; h_d = 8'h50; s_d = 8'h50; end // p
         8'h15: begin l_d = 8'h71; h_d = 8'h51; s_d = 8'h51; end // q
         8'h2D: begin l_d = 8'h72; h_d = 8'h52; s_d = 8'h52; end // r
         8'h1B: begin l_d = 8'h73; h_d = 8'h53; s_d = 8'h53; end // s
         8'h2C: begin l_d = 8'h74; h_d = 8'h54; s_d = 8'h54; end // t
         8'h3C: begin l_d = 8'h75; h_d = 8'h55; s_d = 8'h55; end // u
         8'h2A: begin l_d = 8'h76; h_d = 8'h56; s_d = 8'h56; end // v
         8'h1D: begin l_d = 8'h77; h_d = 8'h57; s_d = 8'h57; end // w
         8'h22: begin l_d = 8'h78; h_d = 8'h58; s_d = 8'h58; end // x
         8'h35: begin l_d = 8'h79; h_d = 8'h59; s_d = 8'h59; end // y
         8'h1A: begin l_d = 8'h7A; h_d = 8'h5A; s_d = 8'h5A; end // z
         // Digits: shifted view is the US-layout symbol.
         8'h16: begin l_d = 8'h31; h_d = 8'h31; s_d = 8'h21; end // 1 !
         8'h1E: begin l_d = 8'h32; h_d = 8'h32; s_d = 8'h40; end // 2 @
         8'h26: begin l_d = 8'h33; h_d = 8'h33; s_d = 8'h23; end // 3 #
         8'h25: begin l_d = 8'h34; h_d = 8'h34; s_d = 8'h24; end // 4 $
         8'h2E: begin l_d = 8'h35; h_d = 8'h35; s_d = 8'h25; end // 5 %
         8'h36: begin l_d = 8'h36; h_d = 8'h36; s_d = 8'h5E; end // 6 ^
         8'h3D: begin l_d = 8'h37; h_d = 8'h37; s_d = 8'h26; end // 7 &
         8'h3E: begin l_d = 8'h38; h_d = 8'h38; s_d = 8'h2A; end // 8 *
         8'h46: begin l_d = 8'h39; h_d = 8'h39; s_d = 8'h28; end // 9 (
         8'h45: begin l_d = 8'h30; h_d = 8'h30; s_d = 8'h29; end // 0 )
         // Punctuation: base on q_l/q_h, shifted on q_s.
         8'h0E: begin l_d = 8'h60; h_d = 8'h60; s_d = 8'h7E; end // ` ~
         8'h4E: begin l_d = 8'h2D; h_d = 8'h2D; s_d = 8'h5F; end // - _
         8'h55: begin l_d = 8'h3D; h_d = 8'h3D; s_d = 8'h2B; end // = +
         8'h54: begin l_d = 8'h5B; h_d = 8'h5B; s_d = 8'h7B; end // [ {
         8'h5B: begin l_d = 8'h5D; h_d = 8'h5D; s_d = 8'h7D; end // ] }
         8'h5D: begin l_d = 8'h5C; h_d = 8'h5C; s_d = 8'h7C; end // \ |
         8'h4C: begin l_d = 8'h3B; h_d = 8'h3B; s_d = 8'h3A; end // ; :
         8'h52: begin l_d = 8'h27; h_d = 8'h27; s_d = 8'h22; end // ' "
         8'h41: begin l_d = 8'h2C; h_d = 8'h2C; s_d = 8'h3C; end // , <
         8'h49: begin l_d = 8'h2E; h_d = 8'h2E; s_d = 8'h3E; end // . >
         8'h4A: begin l_d = 8'h2F; h_d = 8'h2F; s_d = 8'h3F; end // / ?
         // Control keys: identical on all three views.
         8'h29: begin l_d = 8'h20; h_d = 8'h20; s_d = 8'h20; end // space
         8'h5A: begin l_d = 8'h0D; h_d = 8'h0D; s_d = 8'h0D; end // enter
         8'h66: begin l_d = 8'h08; h_d = 8'h08; s_d = 8'h08; end // backspace
         8'h0D: begin l_d = 8'h09; h_d = 8'h09; s_d = 8'h09; end // tab
         8'h76: begin l_d = 8'h1B; h_d = 8'h1B; s_d = 8'h1B; end // esc
         // Prefixes (F0/E0), modifiers, F-keys and everything else.
         default: begin l_d = UNMAPPED; h_d = UNMAPPED; s_d = UNMAPPED; end
      endcase
   end

   // Reset wins over the address on the same edge.
   always_ff @(posedge clock) begin
      if (reset) begin
         l_q <= 8'h00;
         h_q <= 8'h00;
         s_q <= 8'h00;
      end else begin
         l_q <= l_d;
         h_q <= h_d;
         s_q <= s_d;
      end
   end

   assign q_l = l_q;
   assign q_h = h_q;
   assign q_s = s_q;

endmodule

// File: tb/tb_scancode_ascii_rom.sv
module tb_scancode_ascii_rom;

  // ---------------- clock / reset ----------------
  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] address = 8'h00;
  logic [7:0] q_l, q_h, q_s;

  always #5 clock = ~clock;

  scancode_ascii_rom dut (
    .clock   (clock),
    .reset   (reset),
    .address (address),
    .q_l     (q_l),
    .q_h     (q_h),
    .q_s     (q_s)
  );

  // ---------------- golden model ----------------
  logic [7:0] let_codes [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34,
                                 8'h33, 8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31,
                                 8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B, 8'h2C, 8'h3C,
                                 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
  // index = digit value 0..9
  logic [7:0] dig_codes [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36,
                                 8'h3D, 8'h3E, 8'h46};
  logic [7:0] dig_shift [10] = '{8'h29, 8'h21, 8'h40, 8'h23, 8'h24, 8'h25, 8'h5E,
                                 8'h26, 8'h2A, 8'h28};
  logic [7:0] pun_codes [11] = '{8'h0E, 8'h4E, 8'h55, 8'h54, 8'h5B, 8'h5D, 8'h4C,
                                 8'h52, 8'h41, 8'h49, 8'h4A};
  logic [7:0] pun_base  [11] = '{8'h60, 8'h2D, 8'h3D, 8'h5B, 8'h5D, 8'h5C, 8'h3B,
                                 8'h27, 8'h2C, 8'h2E, 8'h2F};
  logic [7:0] pun_shift [11] = '{8'h7E, 8'h5F, 8'h2B, 8'h7B, 8'h7D, 8'h7C, 8'h3A,
                                 8'h22, 8'h3C, 8'h3E, 8'h3F};
  logic [7:0] ctl_codes [5] = '{8'h29, 8'h5A, 8'h66, 8'h0D, 8'h76};
  logic [7:0] ctl_ascii [5] = '{8'h20, 8'h0D, 8'h08, 8'h09, 8'h1B};

  function automatic logic [23:0] gold(input logic [7:0] a);
    logic [7:0] c;
    logic [23:0] r;
    r = 24'h000000;
    for (int i = 0; i < 26; i++)
      if (let_codes[i] == a) r = {8'h61 + 8'(i), 8'h41 + 8'(i), 8'h41 + 8'(i)};
    for (int i = 0; i < 10; i++)
      if (dig_codes[i] == a) begin
        c = 8'h30 + 8'(i);
        r = {c, c, dig_shift[i]};
      end
    for (int i = 0; i < 11; i++)
      if (pun_codes[i] == a) r = {pun_base[i], pun_base[i], pun_shift[i]};
    for (int i = 0; i < 5; i++)
      if (ctl_codes[i] == a) r = {ctl_ascii[i], ctl_ascii[i], ctl_ascii[i]};
    return r;
  endfunction

  // ---------------- scoreboard ----------------
  logic [23:0] exp_q[$];
  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [23:0] act, input logic [23:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got l/h/s=%h/%h/%h expected %h/%h/%h", name,
               act[23:16], act[15:8], act[7:0], exp[23:16], exp[15:8], exp[7:0]);
    end
  endtask

  // Drive one cycle at the falling edge, push the expectation, compare after
  // the following rising edge.
  task automatic apply(input string name, input logic r, input logic [7:0] a,
                       input logic [23:0] e);
    @(negedge clock);
    reset   = r;
    address = a;
    exp_q.push_back(e);
    @(posedge clock);
    #1;
    check(name, {q_l, q_h, q_s}, exp_q.pop_front());
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    string       name;
    logic        rst;
    logic [7:0]  addr;
    logic [23:0] exp;
  } vec_t;

  vec_t vecs[$];

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : main
    logic [23:0] g;
    logic        inv_ok;

    vecs.push_back('{"reset_hold",    1'b1, 8'h1C, 24'h000000});
    vecs.push_back('{"reset_release", 1'b0, 8'h1C, 24'h614141});
    vecs.push_back('{"punct_4A",      1'b0, 8'h4A, 24'h2F2F3F});
    vecs.push_back('{"punct_52",      1'b0, 8'h52, 24'h272722});
    vecs.push_back('{"punct_0E",      1'b0, 8'h0E, 24'h60607E});
    vecs.push_back('{"punct_55",      1'b0, 8'h55, 24'h3D3D2B});
    vecs.push_back('{"ctrl_29",       1'b0, 8'h29, 24'h202020});
    vecs.push_back('{"ctrl_5A",       1'b0, 8'h5A, 24'h0D0D0D});
    vecs.push_back('{"ctrl_66",       1'b0, 8'h66, 24'h080808});
    vecs.push_back('{"unmap_F0",      1'b0, 8'hF0, 24'h000000});
    vecs.push_back('{"unmap_E0",      1'b0, 8'hE0, 24'h000000});
    vecs.push_back('{"unmap_12",      1'b0, 8'h12, 24'h000000});
    vecs.push_back('{"unmap_58",      1'b0, 8'h58, 24'h000000});
    vecs.push_back('{"unmap_FF",      1'b0, 8'hFF, 24'h000000});
    vecs.push_back('{"unmap_00",      1'b0, 8'h00, 24'h000000});

    // Let the DUT see a few reset edges before the table starts.
    repeat (3) @(posedge clock);

    foreach (vecs[i]) apply(vecs[i].name, vecs[i].rst, vecs[i].addr, vecs[i].exp);

    // Latency: output holds across an address change until the next edge.
    apply("lat_first", 1'b0, 8'h1C, 24'h614141);
    @(negedge clock);
    address = 8'h16;
    #1;
    check("lat_hold", {q_l, q_h, q_s}, 24'h614141);
    exp_q.push_back(24'h313121);
    @(posedge clock);
    #1;
    check("lat_update", {q_l, q_h, q_s}, exp_q.pop_front());

    // Reset mid-stream overrides a mapped address, then lookups resume.
    apply("mid_pre",    1'b0, 8'h2D, 24'h725252);
    apply("mid_reset",  1'b1, 8'h2D, 24'h000000);
    apply("mid_resume", 1'b0, 8'h2D, 24'h725252);

    // Back-to-back random mapped/unmapped codes.
    for (int i = 0; i < 32; i++) begin
      logic [7:0] a;
      a = 8'($urandom_range(0, 255));
      apply("random", 1'b0, a, gold(a));
    end

    // Exhaustive sweep with the controller-facing invariant.
    for (int a = 0; a < 256; a++) begin
      g = gold(8'(a));
      apply($sformatf("sweep_%02h", a), 1'b0, 8'(a), g);
      inv_ok = (q_s == q_h) || ((q_s != q_l) && (q_s != q_h));
      check($sformatf("invariant_%02h", a), {23'd0, inv_ok}, 24'h000001);
    end

    // Every letter: q_h is q_l minus the ASCII case offset.
    for (int i = 0; i < 26; i++) begin
      apply($sformatf("letter_%0d", i), 1'b0, let_codes[i], gold(let_codes[i]));
      check($sformatf("case_offset_%0d", i), {16'd0, q_h}, {16'd0, q_l - 8'h20});
    end

    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: %0d entries left, 0 expected", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
